// File: rtl/act_requant.sv
// act_requant: requantises a stream of signed accumulators to signed int8.
// Each beat is multiplied by an unsigned scale, then rounded (half toward
// +inf), arithmetically right-shifted and clamped to [-128,127]. The int8
// stream feeds the GELU LUT address.
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   start, len, scale,   launch a vector; config is sampled when start is
//   shift                accepted in IDLE
//   in_valid/in_ready    accumulator stream (in_data, signed ACC_W)
//   out_valid/out_ready  int8 result stream (out_data)
//   busy                 high while a vector is running
//   done                 one-cycle pulse after the last output handshake
//   sat_count            clamped outputs in the current/last vector
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start; config and counters hold their last values
// RUN   | accepting len inputs and emitting len outputs
module act_requant #(
  parameter int ACC_W   = 32,
  parameter int SCALE_W = 16,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [CNT_W-1:0]   len,
  input  logic [SCALE_W-1:0] scale,
  input  logic [4:0]         shift,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [ACC_W-1:0]   in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [7:0]         out_data,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   sat_count
);

  localparam int PW = ACC_W + SCALE_W + 1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic signed [PW:0] MAX8 = (PW+1)'(127);
  localparam logic signed [PW:0] MIN8 = -(PW+1)'(128);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t state, state_next;
  logic   done_next;

  logic [CNT_W-1:0]   len_q;
  logic [SCALE_W-1:0] scale_q;
  logic [4:0]         shift_q;
  logic [CNT_W-1:0]   in_cnt, out_cnt;

  logic               s1_valid;
  logic signed [PW-1:0] s1_prod;

  logic adv, in_hs, out_hs, start_ok, last_out;

  assign adv      = !out_valid || out_ready;
  assign in_ready = (state == RUN) && (in_cnt < len_q) && adv;
  assign in_hs    = in_valid && in_ready;
  assign out_hs   = out_valid && out_ready;
  assign start_ok = (state == IDLE) && start;
  assign last_out = out_hs && ((out_cnt + CNT_ONE) == len_q);
  assign busy     = (state == RUN);

  // Stage 1 multiply: both operands widened to the product width so the
  // signed multiply is exact; scale is zero-extended.
  logic signed [PW-1:0] mul_a, mul_b, prod_c;
  assign mul_a  = {{(SCALE_W+1){in_data[ACC_W-1]}}, in_data};
  assign mul_b  = {{(ACC_W+1){1'b0}}, scale_q};
  assign prod_c = mul_a * mul_b;

  // Stage 2 round/shift/clamp. One extra bit of headroom keeps the rounding
  // add from overflowing.
  logic signed [PW:0] ext, rnd, rsum, shd;
  logic [7:0]         q8;
  logic               clamp_hit;

  always_comb begin
    ext = {s1_prod[PW-1], s1_prod};
    rnd = '0;
    if (shift_q != 5'd0) rnd[shift_q - 5'd1] = 1'b1;
    rsum      = ext + rnd;
    shd       = rsum >>> shift_q;
    clamp_hit = 1'b0;
    q8        = shd[7:0];
    if (shd > MAX8) begin
      q8        = 8'h7f;
      clamp_hit = 1'b1;
    end else if (shd < MIN8) begin
      q8        = 8'h80;
      clamp_hit = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    done_next  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (len != '0) state_next = RUN;
          else           done_next  = 1'b1;
        end
      end
      RUN: begin
        if (last_out) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done    <= 1'b0;
      len_q   <= '0;
      scale_q <= '0;
      shift_q <= '0;
      in_cnt  <= '0;
      out_cnt <= '0;
    end else begin
      done <= done_next;
      if (start_ok) begin
        len_q   <= len;
        scale_q <= scale;
        shift_q <= shift;
        in_cnt  <= '0;
        out_cnt <= '0;
      end else begin
        if (in_hs)  in_cnt  <= in_cnt + CNT_ONE;
        if (out_hs) out_cnt <= out_cnt + CNT_ONE;
      end
    end
  end

  // Both stages move together on adv, so a stalled output freezes the whole
  // pipe and no beat can be overwritten or replayed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_prod   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (adv) begin
      s1_valid  <= in_hs;
      if (in_hs) s1_prod <= prod_c;
      out_valid <= s1_valid;
      if (s1_valid) out_data <= q8;
    end
  end

  // The pipe is always empty in IDLE, so clearing on start cannot race with
  // a clamped beat entering stage 2.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_count <= '0;
    end else if (start_ok) begin
      sat_count <= '0;
    end else if (adv && s1_valid && clamp_hit && (sat_count != '1)) begin
      sat_count <= sat_count + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_act_requant.sv
// Directed bench for act_requant: hand-computed int8 results, stall,
// zero-length, ignored restart and mid-vector reset.
module tb_act_requant;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] len;
  logic [15:0] scale;
  logic [4:0]  shift;
  logic        in_valid, in_ready;
  logic [31:0] in_data;
  logic        out_valid, out_ready;
  logic [7:0]  out_data;
  logic        busy, done;
  logic [15:0] sat_count;

  always #5 clk = ~clk;

  act_requant dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len), .scale(scale),
    .shift(shift), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .busy(busy), .done(done), .sat_count(sat_count)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int vec_in[16];
  int exp_out[16];
  int got[16];
  int done_cyc, busy_cyc;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Runs one vector. out_ready is low for cycles lo_a..lo_b, a stray start
  // is pulsed at restart_at, and reset is asserted once rst_after outputs
  // have been taken (0 = never).
  task automatic run_vec(input string name, input int n, input int sc,
                         input int sh, input int lo_a, input int lo_b,
                         input int restart_at, input int rst_after,
                         input int exp_sat, input int exp_lat);
    int in_idx, got_n, cyc, first_out, prev_data;
    bit prev_stall, fin, was_reset;
    in_idx = 0; got_n = 0; cyc = 0; first_out = -1; prev_data = 0;
    prev_stall = 0; fin = 0; was_reset = 0;
    done_cyc = -1; busy_cyc = 0;
    start = 1'b1; len = n[15:0]; scale = sc[15:0]; shift = sh[4:0];
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    while (!fin && cyc < 100) begin
      in_valid  = (in_idx < n);
      in_data   = vec_in[in_idx];
      out_ready = !(cyc >= lo_a && cyc <= lo_b);
      if (cyc == restart_at) begin
        start = 1'b1; len = 16'd2; scale = 16'd5; shift = 5'd1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      if (busy) busy_cyc++;
      if (n == 0) check_eq({name, " in_ready idle"}, int'(in_ready), 0);
      if (prev_stall) begin
        check_eq({name, " hold valid"}, int'(out_valid), 1);
        check_eq({name, " hold data"}, int'($signed(out_data)), prev_data);
      end
      if (out_valid && !out_ready)
        check_eq({name, " in_ready full"}, int'(in_ready), 0);
      prev_stall = out_valid && !out_ready;
      prev_data  = int'($signed(out_data));
      if (in_valid && in_ready) in_idx++;
      if (out_valid && out_ready) begin
        if (first_out < 0) first_out = cyc;
        if (got_n < 16) got[got_n] = int'($signed(out_data));
        got_n++;
      end
      if (done) begin
        done_cyc = cyc;
        fin = 1;
        check_eq({name, " busy at done"}, int'(busy), 0);
      end
      if (rst_after > 0 && got_n == rst_after && !fin) begin
        rst_n = 1'b0;
        #1;
        check_eq({name, " rst out_valid"}, int'(out_valid), 0);
        check_eq({name, " rst out_data"}, int'(out_data), 0);
        check_eq({name, " rst in_ready"}, int'(in_ready), 0);
        check_eq({name, " rst busy"}, int'(busy), 0);
        check_eq({name, " rst sat"}, int'(sat_count), 0);
        fin = 1;
        was_reset = 1;
      end
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    if (!was_reset) begin
      check_eq({name, " finished"}, int'(fin), 1);
      check_eq({name, " count"}, got_n, n);
      for (int i = 0; i < n && i < 16; i++)
        check_eq($sformatf("%s out[%0d]", name, i), got[i], exp_out[i]);
      check_eq({name, " sat_count"}, int'(sat_count), exp_sat);
      if (exp_lat >= 0) check_eq({name, " latency"}, first_out, exp_lat);
      @(negedge clk);
      check_eq({name, " done single"}, int'(done), 0);
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; len = '0; scale = '0; shift = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("reset out_valid", int'(out_valid), 0);
    check_eq("reset in_ready", int'(in_ready), 0);
    check_eq("reset busy", int'(busy), 0);
    check_eq("reset done", int'(done), 0);
    check_eq("reset sat", int'(sat_count), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // scale 1, shift 0: pass-through with clamp on both rails
    vec_in[0] = 100; vec_in[1] = 200; vec_in[2] = -300;
    exp_out[0] = 100; exp_out[1] = 127; exp_out[2] = -128;
    run_vec("clamp", 3, 1, 0, -1, -2, -1, 0, 2, 2);
    check_eq("clamp done cycle", done_cyc, 5);

    // scale 3, shift 2: 15->4, -15->-4, 18->5
    vec_in[0] = 5; vec_in[1] = -5; vec_in[2] = 6;
    exp_out[0] = 4; exp_out[1] = -4; exp_out[2] = 5;
    run_vec("round", 3, 3, 2, -1, -2, -1, 0, 0, 2);

    // shift 1: rounding half up, and the exact -128 edge is not a clamp
    vec_in[0] = -3; vec_in[1] = 3; vec_in[2] = 255; vec_in[3] = -257;
    exp_out[0] = -1; exp_out[1] = 2; exp_out[2] = 127; exp_out[3] = -128;
    run_vec("edge", 4, 1, 1, -1, -2, -1, 0, 1, 2);

    // back-pressure on cycles 3..7
    for (int i = 0; i < 8; i++) begin
      vec_in[i]  = i * 10 - 30;
      exp_out[i] = i * 10 - 30;
    end
    run_vec("stall", 8, 1, 0, 3, 7, -1, 0, 0, 2);

    // zero-length vector
    run_vec("len0", 0, 1, 0, -1, -2, -1, 0, 0, -1);
    check_eq("len0 done cycle", done_cyc, 0);
    check_eq("len0 busy cycles", busy_cyc, 0);

    // stray start mid-vector must not disturb the running one
    vec_in[0] = 10; vec_in[1] = -20; vec_in[2] = 30; vec_in[3] = -40;
    exp_out[0] = 10; exp_out[1] = -20; exp_out[2] = 30; exp_out[3] = -40;
    run_vec("restart", 4, 1, 0, -1, -2, 2, 0, 0, 2);

    // reset after 3 of 6 outputs
    vec_in[0] = 200; vec_in[1] = 300; vec_in[2] = 1;
    vec_in[3] = 2;   vec_in[4] = 3;   vec_in[5] = 4;
    run_vec("midrst", 6, 1, 0, -1, -2, -1, 3, 0, -1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    in_valid = 1'b1; in_data = 32'd7;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("post-rst in_ready", int'(in_ready), 0);
      check_eq("post-rst busy", int'(busy), 0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    vec_in[0] = 5; vec_in[1] = 6;
    exp_out[0] = 5; exp_out[1] = 6;
    run_vec("after rst", 2, 1, 0, -1, -2, -1, 0, 0, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/act_requant.md
ACT_REQUANT -- requirements
Module: act_requant

Interface
REQ-001 Parameter ACC_W, default 32, signed accumulator input width.
REQ-002 Parameter SCALE_W, default 16, unsigned requant multiplier width.
REQ-003 Parameter CNT_W, default 16, element-count width.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  one-cycle pulse that launches a vector; honoured only in IDLE.
REQ-007 len  input  CNT_W  element count, sampled on accepted start.
REQ-008 scale  input  SCALE_W  unsigned multiplier, sampled on accepted start.
REQ-009 shift  input  5  right-shift amount 0..31, sampled on accepted start.
REQ-010 in_valid / in_ready  input / output  1 each  accumulator stream handshake.
REQ-011 in_data  input  ACC_W  signed int32 accumulator.
REQ-012 out_valid / out_ready  output / input  1 each  int8 stream handshake; the int8 stream feeds the GELU LUT address.
REQ-013 out_data  output  8  signed int8 result.
REQ-014 busy  output  1  high in RUN.
REQ-015 done  output  1  one-cycle completion pulse.
REQ-016 sat_count  output  CNT_W  number of clamped outputs in the current or last vector.

Function
REQ-017 States: IDLE and RUN; IDLE->RUN on start with len>0; RUN->IDLE on the handshake of output number len.
REQ-018 A start with len==0 in IDLE shall produce done one cycle later with no transfers, and the block shall remain in IDLE.
REQ-019 start while in RUN shall be ignored, with no change to the latched configuration or the counters.
REQ-020 Pipeline of two register stages: S1 product = in_data * zero-extended scale (signed, ACC_W+SCALE_W+1 bits); S2 rounds, shifts, clamps and drives out_data/out_valid.
REQ-021 Rounding: when shift>0, add 2^(shift-1) before the arithmetic right shift (round half toward +inf); when shift==0, pass through.
REQ-022 Clamp: the shifted value shall be clamped to [-128,127]; each clamped output shall increment sat_count, which saturates at all-ones and is cleared on accepted start.
REQ-023 Stall: adv = !out_valid || out_ready; when adv is low, both stages shall hold their values; no beat shall be dropped or duplicated.
REQ-024 in_ready = RUN && (in_cnt < len) && adv.
REQ-025 in_cnt shall increment on each input handshake; out_cnt shall increment on each output handshake; both shall be cleared on accepted start.
REQ-026 Latency: with out_ready held high, out_valid shall assert exactly 2 cycles after an input handshake; sustained throughput is 1 beat/cycle.
REQ-027 done shall pulse in the cycle after the last output handshake, coincident with busy falling.
REQ-028 out_data shall remain stable while out_valid && !out_ready.

Reset
REQ-029 While rst_n is low: state=IDLE; out_valid=0, out_data=0, in_ready=0, busy=0, done=0, sat_count=0; counters and pipeline valids cleared.
REQ-030 Reset asserted mid-vector shall discard all in-flight beats; after release the block shall require a new start.

Verification
REQ-031 scale=1, shift=0, len=3, in {100,200,-300} -> out {100,127,-128}, sat_count=2, done once.
REQ-032 scale=3, shift=2, in {5,-5,6} -> out {4,-4,5}, sat_count=0.
REQ-033 len=8, in_valid high every cycle, out_ready low for cycles 3..7 -> the 8 outputs arrive in order, none lost; in_ready low while the pipeline is full.
REQ-034 start with len=0 -> done one cycle later, busy never asserts, in_ready stays 0.
REQ-035 start pulsed again mid-vector with len=2 -> ignored; the original len completes.
REQ-036 rst_n low after 3 of 6 outputs -> all outputs 0 immediately; a new start with len=2 completes cleanly with sat_count restarted.
